// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// The forced-error timeout is built only with WB_ARB_TIMEOUT_EN defined.
package wb_arb_pkg;

    localparam int MAXM = 32;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // First set bit of req scanning upward from last+1, wrapping at n.
    function automatic pick_t rr_pick(
        input logic [MAXM-1:0] req,
        input logic [5:0]      n,
        input logic [4:0]      last
    );
        pick_t      p;
        logic [5:0] j;
        p = '0;
        for (int k = 1; k <= MAXM; k++) begin
            j = {1'b0, last} + 6'(k);
            if (j >= n) j = j - n;
            if (!p.found && (6'(k) <= n) && req[j[4:0]]) begin
                p.found = 1'b1;
                p.idx   = j[4:0];
            end
        end
        return p;
    endfunction

    function automatic int cnt_width(input int t);
        int w;
        w = $clog2(t + 1);
        if (w < 8)  w = 8;
        if (w > 32) w = 32;
        return w;
    endfunction

endpackage

// File: rtl/wb_arb_if.sv
// Request/grant bundle between the Wishbone masters, the selected
// slave response and the round-robin arbiter.
interface wb_arb_if #(
    parameter int NUMM = 3
);
    localparam int IDX_W = $clog2(NUMM);

    logic [NUMM-1:0]  cyc_i;
    logic [NUMM-1:0]  stb_i;
    logic             ack_i;
    logic             err_i;
    logic [NUMM-1:0]  gnt_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic             gnt_valid_o;
    logic             timeout_o;

    modport master (
        output cyc_i, stb_i, ack_i, err_i,
        input  gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
    );

    modport slave (
        input  cyc_i, stb_i, ack_i, err_i,
        output gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
    );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational masked priority encoder: first requester after last.
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NUMM  = 3,
    parameter int IDX_W = $clog2(NUMM)
) (
    input  logic [NUMM-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [MAXM-1:0] w_req;
    pick_t           w_pk;

    assign w_req   = MAXM'(i_req);
    assign w_pk    = rr_pick(w_req, 6'(NUMM), 5'(i_last));
    assign o_idx   = IDX_W'(w_pk.idx);
    assign o_found = w_pk.found;

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone bus arbiter, grant held for a whole CYC frame.
// Optional hung-transfer timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NUMM    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_arb_if.slave  bus
);

    localparam int IDX_W = $clog2(NUMM);

    arb_state_e       r_state;
    arb_state_e       w_state_nx;
    logic [NUMM-1:0]  r_gnt;
    logic [NUMM-1:0]  w_gnt_nx;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nx;
    logic             r_valid;
    logic             w_valid_nx;
    logic [IDX_W-1:0] w_pick;
    logic             w_found;

    wb_rr_picker #(
        .NUMM  (NUMM),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (bus.cyc_i),
        .i_last  (r_last),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    // The owner's own CYC is low when the picker is consulted in GRANT,
    // so a handover naturally favours the other requesters.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_idx_nx   = r_idx;
        w_last_nx  = r_last;
        w_valid_nx = r_valid;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx = GRANT;
                    w_gnt_nx   = NUMM'(1) << w_pick;
                    w_idx_nx   = w_pick;
                    w_last_nx  = w_pick;
                    w_valid_nx = 1'b1;
                end
            end
            GRANT: begin
                if (!bus.cyc_i[r_idx]) begin
                    if (w_found) begin
                        w_gnt_nx   = NUMM'(1) << w_pick;
                        w_idx_nx   = w_pick;
                        w_last_nx  = w_pick;
                    end else begin
                        w_state_nx = IDLE;
                        w_gnt_nx   = '0;
                        w_idx_nx   = '0;
                        w_valid_nx = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_last  <= IDX_W'(NUMM - 1);
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_idx   <= w_idx_nx;
            r_last  <= w_last_nx;
            r_valid <= w_valid_nx;
        end
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.gnt_idx_o   = r_idx;
    assign bus.gnt_valid_o = r_valid;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          w_busy;
    logic          w_term;
    logic          w_chg;

    assign w_chg  = (w_gnt_nx != r_gnt);
    assign w_busy = r_valid && bus.stb_i[r_idx]
                    && !bus.ack_i && !bus.err_i;
    assign w_term = (r_cnt == CW'(TIMEOUT));

    // Terminal count pulses only while still stalled; a same-cycle ACK wins.
    always_ff @(posedge clk) begin
        if (!rst_n || w_chg || !w_busy || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.timeout_o = w_busy && w_term;
`else
    logic w_unused;

    assign w_unused      = ^{bus.stb_i, bus.ack_i, bus.err_i};
    assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed self-checking bench for wb_arbiter_rr (NUMM=3, TIMEOUT=8).
module tb_wb_arbiter_rr;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    wb_arb_if #(.NUMM(3)) bus ();

    wb_arbiter_rr #(
        .NUMM    (3),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [2:0] g,
                           input logic [1:0] idx, input logic v);
        chk({tag, ".gnt"}, 32'(bus.gnt_o), 32'(g));
        chk({tag, ".idx"}, 32'(bus.gnt_idx_o), 32'(idx));
        chk({tag, ".valid"}, 32'(bus.gnt_valid_o), 32'(v));
        chk({tag, ".tmo"}, 32'(bus.timeout_o), 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        bus.cyc_i = 3'b000;
        bus.stb_i = 3'b000;
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        tick();
        tick();
        chk_gnt("reset", 3'b000, 2'd0, 1'b0);

        // Three-way contention, then ordered handover
        rst_n     = 1'b1;
        bus.cyc_i = 3'b111;
        tick();
        chk_gnt("t1.first", 3'b001, 2'd0, 1'b1);
        bus.cyc_i = 3'b110;
        tick();
        chk_gnt("t1.second", 3'b010, 2'd1, 1'b1);
        bus.cyc_i = 3'b100;
        tick();
        chk_gnt("t1.third", 3'b100, 2'd2, 1'b1);

        // Owner 2 holds against waiting masters
        bus.cyc_i = 3'b111;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2.hold", 32'(bus.gnt_o), 32'h4);
        end
        bus.cyc_i = 3'b011;
        tick();
        chk_gnt("t2.wrap", 3'b001, 2'd0, 1'b1);
        bus.cyc_i = 3'b010;
        tick();
        chk_gnt("t3.own1", 3'b010, 2'd1, 1'b1);

        // Owner 1 drops and re-raises with master 0 waiting
        bus.cyc_i = 3'b001;
        tick();
        chk_gnt("t3.fair", 3'b001, 2'd0, 1'b1);
        bus.cyc_i = 3'b011;
        tick();
        chk_gnt("t3.keep", 3'b001, 2'd0, 1'b1);

        // Idle, single short request, back to idle
        bus.cyc_i = 3'b000;
        tick();
        chk_gnt("t4.idle0", 3'b000, 2'd0, 1'b0);
        bus.cyc_i = 3'b010;
        tick();
        chk_gnt("t4.single", 3'b010, 2'd1, 1'b1);
        bus.cyc_i = 3'b000;
        tick();
        chk_gnt("t4.idle1", 3'b000, 2'd0, 1'b0);

        // Reset mid-transfer
        bus.cyc_i = 3'b010;
        tick();
        chk_gnt("t5.pre", 3'b010, 2'd1, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_gnt("t5.rst", 3'b000, 2'd0, 1'b0);
        rst_n     = 1'b1;
        bus.cyc_i = 3'b110;
        tick();
        chk_gnt("t5.post", 3'b010, 2'd1, 1'b1);

        // Wrap-around scan from last=1 and last=2
        bus.cyc_i = 3'b101;
        tick();
        chk_gnt("wrap.2", 3'b100, 2'd2, 1'b1);
        bus.cyc_i = 3'b001;
        tick();
        chk_gnt("wrap.0", 3'b001, 2'd0, 1'b1);

`ifdef WB_ARB_TIMEOUT_EN
        // Owner 0 stalled: pulse after 8 counted cycles, then ACK at count 8
        bus.stb_i = 3'b001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t6.cnt", 32'(bus.timeout_o), (i == 8) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t6.once", 32'(bus.timeout_o), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("t6.recnt", 32'(bus.timeout_o), 32'd0);
        end
        tick();
        chk("t6.term", 32'(bus.timeout_o), 32'd1);
        bus.ack_i = 1'b1;
        #1;
        chk("t6.ackwin", 32'(bus.timeout_o), 32'd0);
        tick();
        bus.ack_i = 1'b0;
        bus.stb_i = 3'b000;
        chk("t6.held", 32'(bus.gnt_o), 32'h1);
`else
        // Stalled owner never sees a forced error without the timeout
        bus.stb_i = 3'b001;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("notmo", 32'(bus.timeout_o), 32'd0);
        end
        bus.stb_i = 3'b000;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
